// File: rtl/adc_window_integrator.sv
// Per-pulse ADC window integrator: skips a delay, sums W samples every P samples,
// then shifts and saturates the sum into a single-cycle strobed result.
module adc_window_integrator #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_tdata,
    input  logic              adc_tvalid,
    input  logic              run,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [4:0]        cfg_shift,
    output logic [DATA_W-1:0] val_out,
    output logic              val_valid,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_INTEG = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]         CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]        DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]        DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CNT_W-1:0]         r_delay;
    logic [CNT_W-1:0]         r_width;
    logic [CNT_W-1:0]         r_gap;
    logic [4:0]               r_shift;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0]        r_val_out;
    logic                     r_val_valid;
    logic                     r_overflow;

    logic                     w_start;
    logic                     w_cnt_clr;
    logic                     w_cnt_inc;
    logic                     w_acc_upd;
    logic                     w_win_end;

    logic [CNT_W-1:0]         w_width_eff;
    logic [CNT_W-1:0]         w_period_eff;
    logic signed [ACC_W:0]    w_sum;
    logic                     w_acc_ovf;
    logic signed [ACC_W-1:0]  w_acc_sat;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [ACC_W-DATA_W:0]    w_upper;
    logic                     w_res_ovf;
    logic [DATA_W-1:0]        w_res;

    // Zero width behaves as one; a period shorter than the window collapses to it.
    assign w_width_eff  = (cfg_width == '0) ? CNT_ONE : cfg_width;
    assign w_period_eff = (cfg_period < w_width_eff) ? w_width_eff : cfg_period;

    // One extra bit of headroom so ACC_W overflow can be detected from the top two bits.
    assign w_sum = $signed({r_acc[ACC_W-1], r_acc})
                 + $signed({{(ACC_W+1-DATA_W){adc_tdata[DATA_W-1]}}, adc_tdata});
    assign w_acc_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_acc_sat = w_acc_ovf ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_sum[ACC_W-1:0];

    assign w_shifted = w_acc_sat >>> r_shift;
    assign w_upper   = w_shifted[ACC_W-1:DATA_W-1];
    assign w_res_ovf = !((&w_upper) || !(|w_upper));
    assign w_res     = w_res_ovf ? (w_shifted[ACC_W-1] ? DATA_MIN : DATA_MAX)
                                 : w_shifted[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_acc_upd    = 1'b0;
        w_win_end    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_start      = 1'b1;
                    w_state_next = (cfg_delay == '0) ? S_INTEG : S_DELAY;
                end
            end
            S_DELAY: begin
                if (!run) begin
                    w_state_next = S_IDLE;
                end else if (adc_tvalid) begin
                    if (r_cnt == r_delay - CNT_ONE) begin
                        w_cnt_clr    = 1'b1;
                        w_state_next = S_INTEG;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            S_INTEG: begin
                if (!run) begin
                    w_state_next = S_IDLE;
                end else if (adc_tvalid) begin
                    if (r_cnt == r_width - CNT_ONE) begin
                        w_win_end    = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_state_next = (r_gap == '0) ? S_INTEG : S_GAP;
                    end else begin
                        w_cnt_inc = 1'b1;
                        w_acc_upd = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (!run) begin
                    w_state_next = S_IDLE;
                end else if (adc_tvalid) begin
                    if (r_cnt == r_gap - CNT_ONE) begin
                        w_cnt_clr    = 1'b1;
                        w_state_next = S_INTEG;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_delay     <= '0;
            r_width     <= '0;
            r_gap       <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_val_out   <= '0;
            r_val_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_val_valid <= 1'b0;
            if (w_start) begin
                r_delay    <= cfg_delay;
                r_width    <= w_width_eff;
                r_gap      <= w_period_eff - w_width_eff;
                r_shift    <= cfg_shift;
                r_cnt      <= '0;
                r_acc      <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_cnt_clr) begin
                    r_cnt <= '0;
                end else if (w_cnt_inc) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
                if (w_acc_upd) begin
                    r_acc <= w_acc_sat;
                    if (w_acc_ovf) begin
                        r_overflow <= 1'b1;
                    end
                end
                if (w_win_end) begin
                    r_acc       <= '0;
                    r_val_out   <= w_res;
                    r_val_valid <= 1'b1;
                    if (w_acc_ovf || w_res_ovf) begin
                        r_overflow <= 1'b1;
                    end
                end
            end
        end
    end

    assign val_out   = r_val_out;
    assign val_valid = r_val_valid;
    assign overflow  = r_overflow;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_adc_window_integrator.sv
// Directed bench for adc_window_integrator: a table of window scenarios plus
// hand-written abort, degenerate-config and asynchronous-reset sequences.
module tb_adc_window_integrator;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] adc_tdata;
    logic        adc_tvalid;
    logic        run;
    logic [15:0] cfg_delay;
    logic [15:0] cfg_width;
    logic [15:0] cfg_period;
    logic [4:0]  cfg_shift;
    logic [15:0] val_out;
    logic        val_valid;
    logic        overflow;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    adc_window_integrator #(
        .DATA_W(16),
        .CNT_W (16),
        .ACC_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .adc_tdata (adc_tdata),
        .adc_tvalid(adc_tvalid),
        .run       (run),
        .cfg_delay (cfg_delay),
        .cfg_width (cfg_width),
        .cfg_period(cfg_period),
        .cfg_shift (cfg_shift),
        .val_out   (val_out),
        .val_valid (val_valid),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int delay;
        int width;
        int period;
        int shift;
        int start;
        int step;
        int nsamp;
        bit sparse;
        int nexp;
        int e0;
        int e1;
        int e2;
        bit ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int d, input int w, input int p, input int s);
        cfg_delay  = 16'(d);
        cfg_width  = 16'(w);
        cfg_period = 16'(p);
        cfg_shift  = 5'(s);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int weff;
        int peff;
        int k;
        int nstrobe;
        int ev[3];
        bit exp_last;
        weff    = (v.width == 0) ? 1 : v.width;
        peff    = (v.period < weff) ? weff : v.period;
        k       = 0;
        nstrobe = 0;
        ev[0] = v.e0;
        ev[1] = v.e1;
        ev[2] = v.e2;
        set_cfg(v.delay, v.width, v.period, v.shift);
        run        = 1'b1;
        adc_tvalid = 1'b1;
        adc_tdata  = 16'h0999;  // presented during the start edge, must not be counted
        tick();
        check("start_busy", busy, 1);
        check("start_ovf_clear", overflow, 0);
        for (int j = 0; j < v.nsamp; j++) begin
            adc_tvalid = 1'b1;
            adc_tdata  = 16'(v.start + j * v.step);
            tick();
            exp_last = (j >= v.delay + weff - 1) && (((j - v.delay - (weff - 1)) % peff) == 0);
            check("strobe_pos", val_valid, exp_last);
            if (val_valid) nstrobe++;
            if (exp_last && k < 3) begin
                check("strobe_val", $signed(val_out), ev[k]);
                $display("[TB] vec %0d sample %0d strobe val_out=%0d", id, j, $signed(val_out));
                k++;
            end
            if (v.sparse) begin
                adc_tvalid = 1'b0;
                adc_tdata  = 16'h1234;
                tick();
                check("gap_no_strobe", val_valid, 0);
            end
        end
        check("strobe_count", nstrobe, v.nexp);
        check("overflow", overflow, v.ovf);
        run        = 1'b0;
        adc_tvalid = 1'b0;
        tick();
        check("stop_busy", busy, 0);
        check("stop_no_strobe", val_valid, 0);
    endtask

    initial begin
        vecs[0] = '{2, 3, 5, 0, 1, 1, 15, 1'b0, 3, 12, 27, 42, 1'b0};
        vecs[1] = '{2, 3, 5, 0, 1, 1, 15, 1'b1, 3, 12, 27, 42, 1'b0};
        vecs[2] = '{0, 4, 4, 2, 32767, 0, 4, 1'b0, 1, 32767, 0, 0, 1'b0};
        vecs[3] = '{0, 4, 4, 0, -32768, 0, 4, 1'b0, 1, -32768, 0, 0, 1'b1};
        vecs[4] = '{1, 2, 2, 2, -4, 2, 7, 1'b0, 3, -1, 1, 3, 1'b0};

        rst        = 1'b1;
        run        = 1'b0;
        adc_tvalid = 1'b0;
        adc_tdata  = '0;
        set_cfg(0, 0, 0, 0);
        repeat (3) tick();
        check("rst_val_out", val_out, 0);
        check("rst_val_valid", val_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

        // Abort after two of three window samples; the third arrives with run low.
        set_cfg(2, 3, 5, 0);
        run        = 1'b1;
        adc_tvalid = 1'b1;
        adc_tdata  = 16'h0999;
        tick();
        for (int j = 1; j <= 4; j++) begin
            adc_tdata = 16'(j);
            tick();
            check("abort_pre", val_valid, 0);
        end
        run       = 1'b0;
        adc_tdata = 16'd5;
        tick();
        check("abort_no_strobe", val_valid, 0);
        check("abort_busy", busy, 0);
        set_cfg(0, 3, 3, 0);
        run       = 1'b1;
        adc_tdata = 16'h0999;
        tick();
        for (int j = 0; j < 3; j++) begin
            adc_tdata = 16'd1;
            tick();
            check("restart_strobe", val_valid, (j == 2) ? 1 : 0);
        end
        check("restart_val", $signed(val_out), 3);
        $display("[TB] abort restart val_out=%0d", $signed(val_out));
        run        = 1'b0;
        adc_tvalid = 1'b0;
        tick();

        // Zero width/period with delay 0: a strobe on every sample.
        set_cfg(0, 0, 0, 1);
        run        = 1'b1;
        adc_tvalid = 1'b1;
        adc_tdata  = 16'h0999;
        tick();
        adc_tdata = 16'(5);
        tick();
        check("degen_v0", val_valid, 1);
        check("degen_d0", $signed(val_out), 2);
        adc_tdata = 16'(-3);
        tick();
        check("degen_v1", val_valid, 1);
        check("degen_d1", $signed(val_out), -2);
        adc_tdata = 16'(8);
        tick();
        check("degen_v2", val_valid, 1);
        check("degen_d2", $signed(val_out), 4);
        $display("[TB] degenerate last val_out=%0d", $signed(val_out));
        run        = 1'b0;
        adc_tvalid = 1'b0;
        tick();

        // Async reset mid-INTEG after a saturating window has set outputs non-zero.
        set_cfg(0, 2, 2, 0);
        run        = 1'b1;
        adc_tvalid = 1'b1;
        adc_tdata  = 16'h0999;
        tick();
        adc_tdata = 16'h8000;
        tick();
        tick();
        check("pre_rst_val", $signed(val_out), -32768);
        check("pre_rst_ovf", overflow, 1);
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("arst_val_out", val_out, 0);
        check("arst_val_valid", val_valid, 0);
        check("arst_overflow", overflow, 0);
        check("arst_busy", busy, 0);
        set_cfg(2, 3, 5, 0);
        adc_tdata = 16'h0999;
        #2;
        rst = 1'b0;
        tick();
        check("post_rst_busy", busy, 1);
        for (int j = 0; j < 5; j++) begin
            adc_tdata = 16'(j + 1);
            tick();
            check("post_rst_strobe", val_valid, (j == 4) ? 1 : 0);
        end
        check("post_rst_val", $signed(val_out), 12);
        $display("[TB] post-reset val_out=%0d", $signed(val_out));
        run        = 1'b0;
        adc_tvalid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_window_integrator.md
# adc_window_integrator

Per-pulse ADC window integrator between an ADC capture stream and the experiment FSM's `mac_val_in` / `nl_val_in` inputs. There is one instance per ADC channel.

While `run` is high, the block:
- skips a programmable number of samples (the measured propagation delay),
- integrates a programmable number of samples per optical pulse slot,
- arithmetic-shifts and saturates the sum,
- presents the result as a one-cycle-valid value, one value per pulse period.

## Interface

Clock is `clk`. Reset `rst` is asynchronous and active-high.

Parameters:
- `DATA_W`, default 16: sample and result width, signed two's complement.
- `CNT_W`, default 16: width of the delay/period/width counters and config inputs.
- `ACC_W`, default 32: accumulator width, signed.

Ports:
- `clk`  in  1  — clock.
- `rst`  in  1  — asynchronous reset, active-high.
- `adc_tdata`  in  DATA_W  — raw signed ADC sample.
- `adc_tvalid`  in  1  — sample valid. No backpressure; the block always accepts.
- `run`  in  1  — level enable, driven by the FSM's `mac_run` / `nl_run`.
- `cfg_delay`  in  CNT_W  — samples discarded before the first window.
- `cfg_width`  in  CNT_W  — samples summed per window. 0 is treated as 1.
- `cfg_period`  in  CNT_W  — samples from one window start to the next. A value below the effective width is treated as equal to the width.
- `cfg_shift`  in  5  — arithmetic right shift applied to the final sum.
- `val_out`  out  DATA_W  — integrated, shifted, saturated result.
- `val_valid`  out  1  — single-cycle strobe for `val_out`.
- `overflow`  out  1  — sticky saturation flag.
- `busy`  out  1  — high when the state is not IDLE.

## Operation

- Sample counting: every cycle with `adc_tvalid` high is one sample. Index 0 is the first valid sample after the IDLE→active transition.
- Window membership: window k integrates samples `cfg_delay + k*P` through `cfg_delay + k*P + W - 1`, where W and P are the effective width and period.
- Config latching: all `cfg_*` inputs are latched when leaving IDLE. Later changes have no effect until the next run.

States:
- **IDLE**
  - `run` high moves to DELAY, or to INTEG if `cfg_delay` = 0.
  - On this transition: latch config, clear the counter, clear the accumulator, clear `overflow`.
- **DELAY**
  - Counts valid samples and discards them.
  - On the valid sample with count = `cfg_delay` - 1, go to INTEG with count 0.
- **INTEG**
  - Each valid sample: `acc <= sat_ACC(acc + sext(adc_tdata))`.
  - On the last sample (count = W - 1):
    - result = `sat_DATA((acc + sample) >>> cfg_shift)`;
    - register it to `val_out` and pulse `val_valid`;
    - clear the accumulator;
    - go to GAP, or stay in INTEG if P = W.
- **GAP**
  - Discards P - W valid samples, then returns to INTEG with count 0.

Arithmetic and flags:
- Saturation at either the ACC_W or the DATA_W signed limits sets `overflow`.
- `overflow` stays set until reset or the next IDLE exit.
- The shift is arithmetic and truncates toward negative infinity (floor).

Abort and reset:
- `run` low in any non-IDLE state: next state is IDLE, the partial window is discarded, and no `val_valid` is produced.
- If `run` falls in the same cycle as a window's last sample, the abort wins and no output is produced.
- Asynchronous `rst` at any time forces IDLE and all outputs to their reset values.

## Timing

- Reset values: `val_out` = 0, `val_valid` = 0, `overflow` = 0, `busy` = 0. Internal counter, accumulator, state and latched config are also reset.
- The IDLE→active transition takes one cycle after `run` is sampled high. A sample presented in that same cycle is not counted.
- `val_valid` is high for exactly one cycle: the cycle after the edge at which the window's last sample is accepted.
- `val_out` holds its value until the next strobe.
- Strobes are at least one cycle apart. With W = P = 1, a strobe can occur every cycle.
- `busy` falls in the cycle after `run` is sampled low.
- Gaps in `adc_tvalid` stall all counters; the accumulator holds its value through the gap.

## Test plan

1. **Basic windows.**
   - Stimulus: delay=2, width=3, period=5, shift=0; continuous samples 1, 2, 3, … .
   - Response: `val_out` = 12, then 27, then 42.
   - Each strobe comes one cycle after the sample with value 5, 10 and 15 respectively.
2. **Sparse valid.**
   - Stimulus: same config as scenario 1, with `adc_tvalid` toggling every cycle.
   - Response: values 12, 27, 42, with strobe spacing doubled.
3. **Saturation.**
   - width=4, shift=2, samples 0x7FFF → 0x7FFF with `overflow` = 0.
   - width=4, shift=0, samples 0x8000 → 0x8000 with `overflow` = 1.
   - Then drop `run` and restart → `overflow` = 0.
4. **Abort mid-window.**
   - Stimulus: drop `run` after 2 of 3 window samples; restart with fresh samples of 1.
   - Response: no strobe; `busy` = 0 the next cycle.
   - After restart, the first result is 3. No stale accumulator content survives.
5. **Degenerate config.**
   - Stimulus: delay=0, width=0, period=0, shift=1; samples 5, -3, 8.
   - Response: strobes every cycle with values 2, -2, 4.
6. **Async reset.**
   - Stimulus: assert `rst` mid-INTEG, off the clock edge.
   - Response: all outputs go to 0 immediately.
   - After release with `run` high, the block restarts from sample index 0.
